// File: rtl/dut.sv
// Card-intake controller: debounces card-present, times a fixed session, pulses fin, then waits for removal.
// Optional FIN_HOLD_EN: fin stays high from completion until the card is removed.
module dut #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SESSION_CYCLES  = 8,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic tarjeta_recibida,
    output logic fin
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_DETECT      = 3'd1,
        S_SESSION     = 3'd2,
        S_FIN         = 3'd3,
        S_WAIT_REMOVE = 3'd4
    } state_t;

`ifdef FIN_HOLD_EN
    localparam logic HOLD = 1'b1;
`else
    localparam logic HOLD = 1'b0;
`endif

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] SES_MAX = CNT_W'(SESSION_CYCLES);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            fin   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    fin <= 1'b0;
                    if (tarjeta_recibida) begin
                        state <= S_DETECT;
                        cnt   <= ONE;
                    end
                end
                S_DETECT: begin
                    if (!tarjeta_recibida) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (cnt >= DEB_MAX) begin
                        state <= S_SESSION;
                        cnt   <= ONE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                S_SESSION: begin
                    // card pulled mid-session aborts without completion
                    if (!tarjeta_recibida) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (cnt >= SES_MAX) begin
                        state <= S_FIN;
                        cnt   <= '0;
                        fin   <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                S_FIN: begin
                    state <= S_WAIT_REMOVE;
                    fin   <= HOLD;
                end
                S_WAIT_REMOVE: begin
                    // re-arm only after the card leaves, so a held card cannot start a second session
                    if (!tarjeta_recibida) begin
                        state <= S_IDLE;
                        fin   <= 1'b0;
                    end else begin
                        fin <= HOLD & fin;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    fin   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dut.sv
// Self-checking bench for dut: directed scenarios plus random card traffic against a run-length model.
module tb_dut;

    localparam int D = 4;
    localparam int S = 8;
`ifdef FIN_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tarjeta_recibida = 1'b0;
    logic fin;

    int tests = 0;
    int failed = 0;

    // model: run = consecutive 1 samples while armed; phase 0 armed, 1 fin cycle, 2 awaiting removal
    int run = 0;
    int phase = 0;
    bit exp_fin = 1'b0;

    dut #(.DEBOUNCE_CYCLES(D), .SESSION_CYCLES(S), .CNT_W(8)) u_dut (
        .clk(clk),
        .reset(reset),
        .tarjeta_recibida(tarjeta_recibida),
        .fin(fin)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: fin=%b expected %b", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        run = 0;
        phase = 0;
        exp_fin = 1'b0;
    endtask

    task automatic model_edge(input bit t);
        case (phase)
            0: begin
                exp_fin = 1'b0;
                if (t) begin
                    run++;
                    if (run == D + S + 1) begin
                        exp_fin = 1'b1;
                        phase = 1;
                        run = 0;
                    end
                end else begin
                    run = 0;
                end
            end
            1: begin
                phase = 2;
                exp_fin = HOLD;
            end
            default: begin
                if (!t) begin
                    phase = 0;
                    exp_fin = 1'b0;
                end else begin
                    exp_fin = HOLD & exp_fin;
                end
            end
        endcase
    endtask

    task automatic step(input bit t, input string tag);
        tarjeta_recibida = t;
        @(posedge clk);
        model_edge(t);
        #1;
        check(tag, fin, exp_fin);
    endtask

    task automatic steps(input bit t, input int n, input string tag);
        for (int i = 0; i < n; i++) step(t, tag);
    endtask

    int pulses;

    initial begin
        // reset held with card present
        reset = 1'b1;
        tarjeta_recibida = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", fin, 1'b0);
        end
        reset = 1'b0;
        model_reset();

        // card held 30 cycles: one completion at E0+12, none after
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, "held30");
            if (fin === 1'b1) pulses++;
            if (i == 11) check("held30_pre_edge12", fin, 1'b0);
            if (i == 12) check("held30_edge12", fin, 1'b1);
            if (i == 13) check("held30_edge13", fin, HOLD);
        end
        tests++;
        assert (pulses == (HOLD ? 18 : 1)) else begin
            failed++;
            $error("FAIL held30_count: fin high cycles=%0d expected %0d", pulses, HOLD ? 18 : 1);
        end
        step(1'b0, "remove");
        check("remove_low", fin, 1'b0);
        steps(1'b0, 2, "idle");

        // 3-cycle glitch rejected
        steps(1'b1, 3, "glitch");
        steps(1'b0, 20, "glitch_after");

        // drop at session cycle 8, then normal re-insertion
        steps(1'b1, 11, "drop");
        steps(1'b0, 16, "drop_after");
        steps(1'b1, 20, "reinsert");
        steps(1'b0, 3, "reinsert_remove");

        // async reset mid-session, then full re-debounce
        steps(1'b1, 7, "midsess");
        reset = 1'b1;
        #1;
        check("async_reset_midsess", fin, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, "after_reset");
            if (i == 11) check("after_reset_pre", fin, 1'b0);
            if (i == 12) check("after_reset_fin", fin, 1'b1);
        end
        steps(1'b0, 2, "after_reset_remove");

        // async reset while fin is high
        steps(1'b1, 13, "reset_on_fin");
        check("fin_before_reset", fin, 1'b1);
        reset = 1'b1;
        #1;
        check("async_reset_fin", fin, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        tarjeta_recibida = 1'b0;

        // random traffic, biased toward card present so sessions complete
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 15) != 0, "random");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
